// File: rtl/pkt_pkg.sv
// rtl/pkt_pkg.sv - shared types and length defaults for the packet receiver
package pkt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } entry_t;

  localparam int DEF_MIN_LEN = 4;
  localparam int DEF_MAX_LEN = 64;

endpackage

// File: rtl/pkt_sf_fifo.sv
// rtl/pkt_sf_fifo.sv - store-and-forward buffer with write, commit, rewind and read pointers
module pkt_sf_fifo
  import pkt_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   wr_en,
  input  entry_t wr_entry,
  input  logic   restart,
  input  logic   commit,
  input  logic   drop,
  output logic   full,
  input  logic   rd_en,
  output entry_t rd_entry,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] commit_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] base;
  logic [PW-1:0] wr_next;
  entry_t        mem [DEPTH];

  // A restart abandons the partial packet: this beat lands at commit_ptr instead.
  assign base     = restart ? commit_ptr : wr_ptr;
  assign wr_next  = base + {{AW{1'b0}}, wr_en};
  assign full     = (base[AW] != rd_ptr[AW]) && (base[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (commit_ptr == rd_ptr);
  assign rd_entry = mem[rd_ptr[AW-1:0]];

  // Packet storage; contents are never reset, pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[base[AW-1:0]] <= wr_entry;
  end

  // Pointer update: drop rewinds, commit publishes the packet to the reader.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
    end else begin
      wr_ptr <= drop ? commit_ptr : wr_next;
      if (commit) commit_ptr <= wr_next;
      if (rd_en)  rd_ptr     <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/pkt_rx.sv
// rtl/pkt_rx.sv - packet receiver with length check and store-and-forward egress; PKT_RX_STATS_EN adds counters
module pkt_rx
  import pkt_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int MIN_LEN = DEF_MIN_LEN,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data,
  input  logic        sop,
  input  logic        eop,
  input  logic        vld,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_vld,
  input  logic        out_rdy
`ifdef PKT_RX_STATS_EN
  ,
  output logic [31:0] good_cnt,
  output logic [31:0] drop_cnt,
  output logic [31:0] stray_cnt
`endif
);

  localparam int             LW      = $clog2(MAX_LEN + 2);
  localparam logic [LW-1:0]  LEN_SAT = LW'(MAX_LEN + 1);
  localparam logic [LW-1:0]  LEN_MIN = LW'(MIN_LEN);
  localparam logic [LW-1:0]  LEN_MAX = LW'(MAX_LEN);

  rx_state_e     state, state_nxt;
  logic [LW-1:0] len_q, len_nxt;
  logic          ovf_q, ovf_nxt;
  logic          in_pkt;
  logic          wr_en, restart, commit, drop, full;
  logic          rd_en, empty;
  logic          first_q;
  entry_t        wr_entry, rd_entry;

  assign wr_entry = '{last: eop, data: data};

  pkt_sf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_entry (wr_entry),
    .restart  (restart),
    .commit   (commit),
    .drop     (drop),
    .full     (full),
    .rd_en    (rd_en),
    .rd_entry (rd_entry),
    .empty    (empty)
  );

  // Ingress state, running length and overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      len_q <= len_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  // Ingress decode: start/continue packet, gate writes, decide commit or drop at eop.
  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    ovf_nxt   = ovf_q;
    in_pkt    = 1'b0;
    wr_en     = 1'b0;
    restart   = 1'b0;
    commit    = 1'b0;
    drop      = 1'b0;
    if (vld) begin
      if (sop) begin
        restart = (state == BODY);
        len_nxt = LW'(1);
        ovf_nxt = full;
        in_pkt  = 1'b1;
      end else if (state == BODY) begin
        len_nxt = (len_q == LEN_SAT) ? len_q : len_q + LW'(1);
        ovf_nxt = ovf_q | full;
        in_pkt  = 1'b1;
      end
      if (in_pkt) begin
        wr_en     = !ovf_nxt && (len_nxt <= LEN_MAX);
        state_nxt = eop ? IDLE : BODY;
        if (eop) begin
          if (!ovf_nxt && (len_nxt >= LEN_MIN) && (len_nxt <= LEN_MAX)) commit = 1'b1;
          else                                                            drop   = 1'b1;
        end
      end
    end
  end

  // Load the egress register whenever it is empty or its beat is being taken.
  assign rd_en = (!out_vld || out_rdy) && !empty;

  // Registered egress; first_q marks that the next loaded byte starts a packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      out_data <= '0;
      first_q  <= 1'b1;
    end else if (rd_en) begin
      out_vld  <= 1'b1;
      out_sop  <= first_q;
      out_eop  <= rd_entry.last;
      out_data <= rd_entry.data;
      first_q  <= rd_entry.last;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

`ifdef PKT_RX_STATS_EN
  // Packet statistics; an aborted packet (sop inside a packet) counts as dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt  <= '0;
      drop_cnt  <= '0;
      stray_cnt <= '0;
    end else begin
      good_cnt  <= good_cnt + 32'(commit);
      drop_cnt  <= drop_cnt + 32'(drop) + 32'(restart);
      stray_cnt <= stray_cnt + 32'(vld && !sop && (state == IDLE));
    end
  end
`endif

endmodule
